// File: rtl/axi_stream_pkg.sv
// Shared definitions for the AXI-Stream packet master.
//   pm_state_t      : FSM state encoding (IDLE offers a command slot, SEND drives beats)
//   max_byte_width  : largest TDATA byte width the keep-mask helper supports
//   last_keep_mask  : TKEEP pattern for the final beat of a packet, given the
//                     byte remainder (bytes mod byte_width) and the bus byte width
package axi_stream_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pm_state_t;

    localparam int unsigned max_byte_width = 64;

    // A zero remainder means the last beat is completely full.
    function automatic logic [max_byte_width-1:0] last_keep_mask(input int unsigned rem,
                                                                 input int unsigned bw);
        logic [max_byte_width-1:0] m;
        int unsigned               n;
        m = '0;
        n = (rem == 0) ? bw : rem;
        for (int unsigned i = 0; i < max_byte_width; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_stream_packet_master_if.sv
// AXI-Stream bus bundle used between the packet master and its sink.
//   tvalid/tready : handshake
//   tdata         : 8*byte_width payload
//   tstrb/tkeep   : per-byte qualifiers
//   tlast         : end of packet
//   tid/tdest/tuser : sideband
// Modports: master drives everything except tready; slave is the mirror.
interface axi_stream_packet_master_if #(
    parameter int byte_width = 4,
    parameter int id_width   = 1,
    parameter int dest_width = 1,
    parameter int user_width = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [8*byte_width-1:0] tdata;
    logic [byte_width-1:0]   tstrb;
    logic [byte_width-1:0]   tkeep;
    logic                    tlast;
    logic [id_width-1:0]     tid;
    logic [dest_width-1:0]   tdest;
    logic [user_width-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi_stream_packet_master.sv
// Command-driven AXI-Stream transmitter. One command (byte count, seed,
// sideband) becomes one packet of ceil(bytes/byte_width) beats whose data
// increments from the seed; the last beat carries TLAST and a partial TKEEP.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid / cmd_ready : command handshake (ready only in IDLE, low in reset)
//   cmd_bytes             : packet length in bytes (0 is rejected with err_zero_len)
//   cmd_seed              : TDATA of beat 0
//   cmd_id/dest/user      : sideband held for the whole packet
//   axis                  : AXI-Stream master port
//   busy                  : packet in flight
//   pkt_count             : completed packets (wraps)
//   err_zero_len          : one-cycle pulse after a zero-length command is taken
//
// State | meaning
// IDLE  | cmd_ready high, tvalid low, waiting for a command
// SEND  | tvalid high, presenting beat k until handshake
module axi_stream_packet_master
    import axi_stream_pkg::*;
#(
    parameter int byte_width = 4,
    parameter int id_width   = 1,
    parameter int dest_width = 1,
    parameter int user_width = 1,
    parameter int len_width  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [len_width-1:0]    cmd_bytes,
    input  logic [8*byte_width-1:0] cmd_seed,
    input  logic [id_width-1:0]     cmd_id,
    input  logic [dest_width-1:0]   cmd_dest,
    input  logic [user_width-1:0]   cmd_user,
    axi_stream_packet_master_if.master axis,
    output logic                    busy,
    output logic [31:0]             pkt_count,
    output logic                    err_zero_len
);

    localparam int data_width = 8 * byte_width;

    pm_state_t               state_q;
    logic [len_width-1:0]    k_q;
    logic [len_width-1:0]    last_idx_q;
    logic [byte_width-1:0]   last_keep_q;
    logic [data_width-1:0]   seed_q;

    logic                    tvalid_q;
    logic                    tlast_q;
    logic [data_width-1:0]   tdata_q;
    logic [byte_width-1:0]   tkeep_q;
    logic [id_width-1:0]     tid_q;
    logic [dest_width-1:0]   tdest_q;
    logic [user_width-1:0]   tuser_q;
    logic [31:0]             pkt_count_q;
    logic                    err_q;

    // Command decode: beat count and last-beat mask.
    logic [len_width:0]      bytes_round;
    logic [len_width:0]      beats_ext;
    logic [len_width-1:0]    cmd_last_idx;
    logic [len_width-1:0]    cmd_rem;
    logic [byte_width-1:0]   cmd_last_keep;

    always_comb begin
        bytes_round   = {1'b0, cmd_bytes} + (len_width+1)'(byte_width - 1);
        beats_ext     = bytes_round / (len_width+1)'(byte_width);
        cmd_last_idx  = len_width'(beats_ext - (len_width+1)'(1));
        cmd_rem       = cmd_bytes % len_width'(byte_width);
        cmd_last_keep = byte_width'(last_keep_mask(32'(cmd_rem), byte_width));
    end

    // Next-beat payload. In IDLE it describes beat 0 of the offered command,
    // in SEND it describes beat k+1 of the current packet, so the same
    // adder and mask serve both the load and the advance.
    logic [len_width-1:0]    beat_idx;
    logic [data_width-1:0]   beat_seed;
    logic [len_width-1:0]    beat_last_idx;
    logic [byte_width-1:0]   beat_last_keep;
    logic                    beat_is_last;
    logic [byte_width-1:0]   beat_keep;
    logic [data_width-1:0]   beat_sum;
    logic [data_width-1:0]   beat_data;

    always_comb begin
        if (state_q == ST_IDLE) begin
            beat_idx       = '0;
            beat_seed      = cmd_seed;
            beat_last_idx  = cmd_last_idx;
            beat_last_keep = cmd_last_keep;
        end else begin
            beat_idx       = k_q + len_width'(1);
            beat_seed      = seed_q;
            beat_last_idx  = last_idx_q;
            beat_last_keep = last_keep_q;
        end
        beat_is_last = (beat_idx == beat_last_idx);
        beat_keep    = beat_is_last ? beat_last_keep : '1;
        beat_sum     = beat_seed + data_width'(beat_idx);
        beat_data    = '0;
        for (int i = 0; i < byte_width; i++) begin
            beat_data[8*i +: 8] = beat_keep[i] ? beat_sum[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            last_idx_q  <= '0;
            last_keep_q <= '0;
            seed_q      <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tid_q       <= '0;
            tdest_q     <= '0;
            tuser_q     <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bytes == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            seed_q      <= cmd_seed;
                            last_idx_q  <= cmd_last_idx;
                            last_keep_q <= cmd_last_keep;
                            k_q         <= '0;
                            tid_q       <= cmd_id;
                            tdest_q     <= cmd_dest;
                            tuser_q     <= cmd_user;
                            tdata_q     <= beat_data;
                            tkeep_q     <= beat_keep;
                            tlast_q     <= beat_is_last;
                            tvalid_q    <= 1'b1;
                            state_q     <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    // Without tready nothing here moves, which keeps every
                    // t* output frozen across a stall.
                    if (axis.tready) begin
                        if (tlast_q) begin
                            pkt_count_q <= pkt_count_q + 32'd1;
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tdata_q     <= '0;
                            tkeep_q     <= '0;
                            tid_q       <= '0;
                            tdest_q     <= '0;
                            tuser_q     <= '0;
                            state_q     <= ST_IDLE;
                        end else begin
                            k_q     <= beat_idx;
                            tdata_q <= beat_data;
                            tkeep_q <= beat_keep;
                            tlast_q <= beat_is_last;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE) && !reset;
    assign busy         = (state_q == ST_SEND);
    assign pkt_count    = pkt_count_q;
    assign err_zero_len = err_q;

    assign axis.tvalid = tvalid_q;
    assign axis.tdata  = tdata_q;
    assign axis.tkeep  = tkeep_q;
    assign axis.tstrb  = tkeep_q;
    assign axis.tlast  = tlast_q;
    assign axis.tid    = tid_q;
    assign axis.tdest  = tdest_q;
    assign axis.tuser  = tuser_q;

endmodule
